// File: rtl/rv32i_mem_pkg.sv
// Shared constants and helpers for the rv32i data-memory responder.
package rv32i_mem_pkg;

    // MMIO register select, taken from daddr[3:2]
    localparam logic [1:0] MMIO_UART_DATA = 2'd0;
    localparam logic [1:0] MMIO_STATUS    = 2'd1;
    localparam logic [1:0] MMIO_TIMER_LO  = 2'd2;
    localparam logic [1:0] MMIO_TIMER_HI  = 2'd3;

    // STATUS bit positions; [3:0] hold the FIFO level
    localparam int ST_FULL  = 4;
    localparam int ST_EMPTY = 5;
    localparam int ST_BUSY  = 6;
    localparam int ST_ERR   = 7;

    // Store lane patterns {dwe0,dwe1,dwe2}
    localparam logic [2:0] WE_WORD = 3'b111;
    localparam logic [2:0] WE_HALF = 3'b110;
    localparam logic [2:0] WE_BYTE = 3'b100;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Left-rotate by whole bytes: brings byte 'off' up to [31:24]
    function automatic logic [31:0] rotl32(input logic [31:0] w, input logic [1:0] off);
        logic [63:0] t;
        t = {w, w} << {off, 3'b000};
        return t[63:32];
    endfunction

    // Right-rotate by whole bytes: moves [31:24] down to byte 'off'
    function automatic logic [31:0] rotr32(input logic [31:0] w, input logic [1:0] off);
        logic [63:0] t;
        t = {w, w} >> {off, 3'b000};
        return t[31:0];
    endfunction

    // Right-rotate a 4-bit lane mask (bit 3 = [31:24])
    function automatic logic [3:0] rotr4(input logic [3:0] m, input logic [1:0] off);
        logic [7:0] t;
        t = {m, m} >> off;
        return t[3:0];
    endfunction

    // Word must be word aligned, half must be half aligned, byte goes anywhere
    function automatic logic store_legal(input logic [2:0] we, input logic [1:0] off);
        return ((we == WE_WORD) && (off == 2'd0)) ||
               ((we == WE_HALF) && !off[0]) ||
               (we == WE_BYTE);
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// Core-side data and instruction bus of the memory responder.
interface rv32i_dmem_responder_if;
    logic [31:0] daddr;
    logic [31:0] ddout;
    logic        dwe0;
    logic        dwe1;
    logic        dwe2;
    logic [31:0] ddin;
    logic [31:0] iaddr;
    logic [31:0] idin;

    modport master (output daddr, ddout, dwe0, dwe1, dwe2, iaddr, input ddin, idin);
    modport slave  (input daddr, ddout, dwe0, dwe1, dwe2, iaddr, output ddin, idin);
endinterface

// File: rtl/rv32i_uart_tx.sv
// UART transmitter: small byte FIFO feeding an 8N1 serializer.
module rv32i_uart_tx
    import rv32i_mem_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [7:0]                  data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        drop,
    output logic                        tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   FULL_LVL  = FIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          pop, push_ok, baud_done;
    tx_state_t     state, state_nxt;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign empty     = (level == '0);
    assign full      = (level == FULL_LVL);
    // The serializer only takes a byte while idle; a pop frees a slot for a same-cycle push
    assign pop       = (state == IDLE) && !empty;
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign baud_done = (baud == BAUD_LAST);

    // FIFO storage; flushing is done through the pointers
    always_ff @(posedge clk) begin
        if (push_ok) fifo[wptr] <= data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Serializer next state: each non-idle state lasts one bit period, DATA lasts eight
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!empty)                          state_nxt = START;
            START: if (baud_done)                       state_nxt = DATA;
            DATA:  if (baud_done && (bit_idx == 3'd7))  state_nxt = STOP;
            STOP:  if (baud_done)                       state_nxt = IDLE;
            default:                                    state_nxt = IDLE;
        endcase
    end

    // Serializer outputs: line level and busy flag
    always_comb begin
        tx   = 1'b1;
        busy = (state != IDLE);
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    // Baud/bit counters and LSB-first shifter; counters restart on every idle cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (state == IDLE) begin
            baud    <= '0;
            bit_idx <= '0;
            if (pop) shreg <= fifo[rptr];
        end else if (baud_done) begin
            baud <= '0;
            if (state == DATA) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end else begin
            baud <= baud + 1'b1;
        end
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Memory slave for the rv32i core: shared word RAM with byte-lane stores,
// plus an MMIO window (UART TX, status, 64-bit cycle timer).
module rv32i_dmem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    MEM_WORDS    = 4096,
    parameter string INIT_FILE    = "",
    parameter int    FIFO_DEPTH   = 4,
    parameter int    CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32i_dmem_responder_if.slave bus,
    output logic                  uart_tx,
    output logic                  err_misalign
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [1:0]            off, reg_sel;
    logic [2:0]            we;
    logic [AW-1:0]         didx, iidx;
    logic                  is_mmio, is_store, legal, bad_store;
    logic                  ram_wr, uart_push, st_clear;
    logic [3:0]            lane;
    logic [DATA_WIDTH-1:0] wdata, status, mmio_rdata;
    logic [63:0]           timer;
    logic                  err_sticky;
    logic                  fifo_full, fifo_empty, tx_busy, uart_drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                  unused_addr;

    assign off       = bus.daddr[1:0];
    assign reg_sel   = bus.daddr[3:2];
    assign is_mmio   = bus.daddr[31];
    assign didx      = bus.daddr[AW+1:2];
    assign iidx      = bus.iaddr[AW+1:2];
    assign we        = {bus.dwe0, bus.dwe1, bus.dwe2};
    assign is_store  = |we;
    assign legal     = store_legal(we, off);
    assign bad_store = is_store && !legal;

    assign ram_wr    = is_store && legal && !is_mmio;
    assign uart_push = is_store && legal && is_mmio && (reg_sel == MMIO_UART_DATA)
                       && bus.dwe0 && (off == 2'd0);
    assign st_clear  = is_store && legal && is_mmio && (reg_sel == MMIO_STATUS) && bus.ddout[7];

    // Left-justified store data and lanes slide down to the addressed byte
    assign lane  = rotr4({bus.dwe0, bus.dwe1, bus.dwe2, bus.dwe2}, off);
    assign wdata = rotr32(bus.ddout, off);

    // Address bits above the RAM window are don't-care (the RAM aliases)
    assign unused_addr = ^{bus.daddr[30:AW+2], bus.iaddr[31:AW+2], bus.iaddr[1:0]};

    // Byte-lane RAM write; reads in the same cycle still see the old word
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++)
                if (lane[b]) mem[didx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Free-running cycle timer
    always_ff @(posedge clk) begin
        if (rst) timer <= '0;
        else     timer <= timer + 64'd1;
    end

    // Error pulse and sticky error flag; new errors win over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_misalign <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            err_misalign <= bad_store;
            if (bad_store || uart_drop) err_sticky <= 1'b1;
            else if (st_clear)          err_sticky <= 1'b0;
        end
    end

    // STATUS word assembly
    always_comb begin
        status           = '0;
        status[3:0]      = 4'(fifo_level);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = tx_busy;
        status[ST_ERR]   = err_sticky;
    end

    // Side-effect-free MMIO read mux
    always_comb begin
        mmio_rdata = '0;
        unique case (reg_sel)
            MMIO_STATUS:   mmio_rdata = status;
            MMIO_TIMER_LO: mmio_rdata = timer[31:0];
            MMIO_TIMER_HI: mmio_rdata = timer[63:32];
            default:       mmio_rdata = '0;
        endcase
    end

    // Zero-latency load path: RAM words rotated so the addressed byte sits at [31:24]
    always_comb begin
        bus.ddin = is_mmio ? mmio_rdata : rotl32(mem[didx], off);
        bus.idin = mem[iidx];
    end

    rv32i_uart_tx #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_push),
        .data  (bus.ddout[31:24]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .busy  (tx_busy),
        .drop  (uart_drop),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench for rv32i_dmem_responder: byte-addressed reference memory,
// queued load expectations and a serial-line frame decoder.
module tb_rv32i_dmem_responder;
    localparam int MW  = 64;
    localparam int FD  = 4;
    localparam int CPB = 4;

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
        bit          ichk;
        logic [31:0] i;
        bit          tchk;
        logic        t;
        logic [63:0] nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx, err_misalign;

    rv32i_dmem_responder_if bus();

    rv32i_dmem_responder #(
        .DATA_WIDTH(32), .MEM_WORDS(MW), .INIT_FILE(""),
        .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx), .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    logic [7:0]  mb [MW*4];
    bit          m_sticky = 0;
    logic [63:0] cyc = '0;
    logic [7:0]  uart_q [$];
    exp_t        exp_q [$];
    logic        rd_valid = 1'b0, st_illegal = 1'b0, err_exp = 1'b0;
    bit          mon_busy = 0;
    logic        smp [10*CPB];

    always @(posedge clk) cyc     <= rst ? 64'd0 : cyc + 64'd1;
    always @(posedge clk) err_exp <= rst ? 1'b0 : st_illegal;

    task automatic chk(input logic [63:0] nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h req=%h t=%0t", nm, got, req, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] we, input logic [1:0] off);
        return (we == 3'b111 && off == 2'd0) || (we == 3'b110 && off % 2 == 0) || (we == 3'b100);
    endfunction

    function automatic logic [31:0] m_word(input int w);
        return {mb[w*4], mb[w*4+1], mb[w*4+2], mb[w*4+3]};
    endfunction

    // Reference load: byte k of the result is memory byte (off+k) of the same word.
    // STATUS is only modelled while the UART is idle and its FIFO empty.
    function automatic logic [31:0] m_load(input logic [31:0] a);
        logic [31:0] r;
        int w, o;
        r = '0;
        if (a[31]) begin
            case (a[3:2])
                2'd1:    r = 32'h20 | (m_sticky ? 32'h80 : 32'h0);
                2'd2:    r = cyc[31:0];
                2'd3:    r = cyc[63:32];
                default: r = '0;
            endcase
        end else begin
            w = int'((a >> 2) % MW);
            o = int'(a % 4);
            for (int k = 0; k < 4; k++) r[31-8*k -: 8] = mb[w*4 + (o+k)%4];
        end
        return r;
    endfunction

    // Reference store effects (UART pushes are tracked by the directed code)
    function automatic void m_commit(input logic [31:0] a, input logic [31:0] dout, input logic [2:0] we);
        int n, w, o;
        if (we == 3'b000) return;
        if (!legal(we, a[1:0])) begin
            m_sticky = 1;
        end else if (a[31]) begin
            if (a[3:2] == 2'd1 && dout[7]) m_sticky = 0;
        end else begin
            n = (we == 3'b111) ? 4 : (we == 3'b110) ? 2 : 1;
            w = int'((a >> 2) % MW);
            o = int'(a % 4);
            for (int k = 0; k < n; k++) mb[w*4 + o + k] = dout[31-8*k -: 8];
        end
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [63:0] nm);
        exp_t e;
        e.d = d; e.m = '1; e.ichk = 0; e.i = '0; e.tchk = 0; e.t = 1'b1; e.nm = nm;
        return e;
    endfunction

    // One bus cycle: drive, optionally queue a load expectation, commit at the edge
    task automatic step(input logic [31:0] a, input logic [31:0] dout, input logic [2:0] we,
                        input exp_t e, input bit do_chk);
        bus.daddr = a;
        bus.ddout = dout;
        {bus.dwe0, bus.dwe1, bus.dwe2} = we;
        st_illegal = (we != 3'b000) && !legal(we, a[1:0]);
        if (do_chk) exp_q.push_back(e);
        rd_valid = do_chk;
        @(posedge clk); #1;
        m_commit(a, dout, we);
        {bus.dwe0, bus.dwe1, bus.dwe2} = 3'b000;
        st_illegal = 1'b0;
        rd_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        exp_t e;
        e = mk('0, "idle");
        for (int k = 0; k < n; k++) step(32'h0, 32'h0, 3'b000, e, 0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [63:0] nm);
        step(a, 32'h0, 3'b000, mk(d, nm), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((uart_q.size() != 0 || mon_busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL uart_drain got=timeout req=frames_done left=%0d", uart_q.size());
        end
        idle(3);
    endtask

    // Load-data monitor
    initial begin : rd_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_underflow got=%h req=queued_expectation", bus.ddin);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.nm, bus.ddin & e.m, e.d & e.m);
                    if (e.ichk) chk("idin", bus.idin, e.i);
                    if (e.tchk) chk("uart_tx", {31'h0, uart_tx}, {31'h0, e.t});
                end
            end
        end
    end

    // Error-pulse monitor
    initial begin : err_mon
        forever begin
            @(negedge clk);
            if (!rst) chk("err_mis", {31'h0, err_misalign}, {31'h0, err_exp});
        end
    end

    // Serial frame decoder: start, 8 data bits LSB first, stop, each CPB clocks
    initial begin : uart_mon
        logic [7:0] byt;
        bit glitch, abort;
        forever begin
            @(negedge clk);
            if (rst || uart_tx !== 1'b0) continue;
            mon_busy = 1; abort = 0; smp[0] = uart_tx;
            for (int s = 1; s < 10*CPB; s++) begin
                @(negedge clk);
                if (rst) begin abort = 1; break; end
                smp[s] = uart_tx;
            end
            if (!abort) begin
                glitch = 0;
                for (int s = 0; s < 10*CPB; s++) if (smp[s] !== smp[(s/CPB)*CPB]) glitch = 1;
                for (int b = 0; b < 8; b++) byt[b] = smp[(b+1)*CPB];
                if (uart_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL uart_unexp got=%h req=no_frame", byt);
                end else begin
                    chk("uart_byt", {24'h0, byt}, {24'h0, uart_q.pop_front()});
                end
                chk("uart_frm", {30'h0, glitch, smp[9*CPB]}, 32'h1);
            end
            mon_busy = 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        logic [31:0] a, t, dout;
        logic [2:0] we;
        logic [7:0] b;
        int r;
        bus.daddr = '0; bus.ddout = '0; bus.iaddr = '0;
        {bus.dwe0, bus.dwe1, bus.dwe2} = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        e = mk(32'h20, "rst_st"); e.tchk = 1; e.t = 1'b1;
        step(32'h8000_0004, 32'h0, 3'b000, e, 1);
        rd(32'h8000_0008, m_load(32'h8000_0008), "rst_tlo");
        rd(32'h8000_000C, 32'h0, "rst_thi");

        // Fill RAM so every word is known
        for (int i = 0; i < MW; i++) step(i*4, $urandom, 3'b111, mk('0, "fill"), 0);

        // Word store then rotated loads
        step(32'h10, 32'hA1B2C3D4, 3'b111, mk('0, "sw"), 0);
        rd(32'h10, 32'hA1B2C3D4, "lw10");
        rd(32'h11, 32'hB2C3D4A1, "lb11");
        rd(32'h13, 32'hD4A1B2C3, "lb13");

        // Byte store into lane 2
        step(32'h12, 32'h5A000000, 3'b100, mk('0, "sb"), 0);
        bus.iaddr = 32'h10;
        e = mk(32'hA1B25AD4, "sb_lw"); e.ichk = 1; e.i = 32'hA1B25AD4;
        step(32'h10, 32'h0, 3'b000, e, 1);

        // Misaligned half: suppressed, error pulse, sticky then cleared
        step(32'h13, 32'h12340000, 3'b110, mk('0, "sh"), 0);
        rd(32'h10, 32'hA1B25AD4, "sh_nowr");
        rd(32'h8000_0004, 32'hA0, "st_err");
        step(32'h8000_0004, 32'h80, 3'b111, mk('0, "clr"), 0);
        rd(32'h8000_0004, 32'h20, "st_clr");

        // Randomised mix of loads, stores, MMIO traffic and instruction fetches
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            t = $urandom;
            bus.iaddr = $urandom;
            dout = $urandom;
            we = 3'b000;
            if (r <= 6) a = {1'b0, t[30:0]};
            else        a = {1'b1, t[30:4], (r == 9) ? 2'd0 : 2'($urandom_range(r == 8 ? 1 : 0, 3)), t[1:0]};
            if (r >= 4 && r <= 6) begin
                we = ($urandom_range(0, 3) != 0) ? ((t[5:4] == 2'd0) ? 3'b111 : (t[5:4] == 2'd1) ? 3'b110 : 3'b100)
                                                 : 3'($urandom_range(1, 7));
            end else if (r == 8) begin
                we = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'($urandom_range(1, 7));
                if (we == 3'b111) a[1:0] = 2'd0;
            end else if (r == 9) begin
                t  = $urandom_range(0, 3);
                we = (t == 0) ? 3'b001 : (t == 1) ? 3'b010 : (t == 2) ? 3'b011 : 3'b101;
            end
            e = mk(m_load(a), (we != 3'b000) ? "rnd_st" : "rnd_ld");
            e.ichk = 1; e.i = m_word(int'((bus.iaddr >> 2) % MW));
            step(a, dout, we, e, 1);
        end
        rd(32'h8000_0004, m_load(32'h8000_0004), "rnd_end");
        step(32'h8000_0004, 32'h80, 3'b111, mk('0, "clr"), 0);

        // Single frame of 0x55
        step(32'h8000_0000, 32'h55000000, 3'b111, mk('0, "tx55"), 0);
        uart_q.push_back(8'h55);
        drain();
        rd(32'h8000_0004, 32'h20, "tx_idle");

        // Six back-to-back pushes: one in flight, four queued, sixth dropped
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            step(32'h8000_0000, {b, 24'h0}, 3'b111, mk('0, "push"), 0);
            if (i < 5) uart_q.push_back(b);
            else       m_sticky = 1;
        end
        rd(32'h8000_0004, 32'hD4, "st_full");
        drain();
        rd(32'h8000_0004, 32'hA0, "st_drain");
        step(32'h8000_0004, 32'h80, 3'b111, mk('0, "clr"), 0);

        // Reset in the middle of a frame with a byte still queued
        step(32'h8000_0000, 32'hC3000000, 3'b111, mk('0, "pushc3"), 0);
        uart_q.push_back(8'hC3);
        step(32'h8000_0000, 32'h3C000000, 3'b111, mk('0, "push3c"), 0);
        idle(12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        uart_q.delete();
        m_sticky = 0;
        e = mk(32'h0, "rst_tlo2"); e.tchk = 1; e.t = 1'b1;
        step(32'h8000_0008, 32'h0, 3'b000, e, 1);
        rd(32'h8000_0004, 32'h20, "rst_lvl");
        rd(32'h10, m_load(32'h10), "rst_ram");
        rd(32'h2D, m_load(32'h2D), "rst_ram2");
        idle(100);
        chk("uart_left", uart_q.size() + (mon_busy ? 1 : 0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
